// File: rtl/cpu_control_unit_pkg.sv
// rtl/cpu_control_unit_pkg.sv - shared encodings for the accumulator-machine sequencer
package cpu_control_unit_pkg;

  // Major opcodes, IR[15:12]
  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_JUMP  = 4'h3;
  localparam logic [3:0] OP_JZ    = 4'h4;
  localparam logic [3:0] OP_ALUM  = 4'h5;
  localparam logic [3:0] OP_SETOP = 4'h6;
  localparam logic [3:0] OP_ALUI  = 4'h7;

  // ALU opcodes driven on alu_op; only ADD (reset value) and DIV matter to the sequencer
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_MUL   = 4'b0010;
  localparam logic [3:0] ALU_DIV   = 4'b0011;
  localparam logic [3:0] ALU_CMPEQ = 4'b1110;
  localparam logic [3:0] ALU_CMPLT = 4'b1111;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEMRD  = 3'd4;
  localparam logic [2:0] ST_HALTED = 3'd5;

  // Instructions that need the extra MEMRD cycle to see M[a]
  function automatic logic needs_mem_read(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_ALUM);
  endfunction

endpackage

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle fetch/decode/execute sequencer owning PC, IR, AC and op_reg
module cpu_control_unit
  import cpu_control_unit_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 14,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              halted,
  output logic              err
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [3:0]        op_q, op_d;
  logic              err_q, err_d;

  logic [3:0]        major;
  logic [ADDR_W-1:0] operand_addr;
  logic              div_by_zero;

  assign major        = ir_q[15:12];
  assign operand_addr = ADDR_W'(ir_q[11:0]);
  // Divide-by-zero is judged on whatever operand the ALU currently sees
  assign div_by_zero  = (op_q == ALU_DIV) && (alu_b == '0);

  // Next-state and register update logic for the instruction sequencer
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ac_d    = ac_q;
    op_d    = op_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (needs_mem_read(major)) begin
          state_d = ST_MEMRD;
        end else begin
          case (major)
            OP_HALT:  state_d = ST_HALTED;
            OP_STORE: ;
            OP_JUMP:  pc_d = operand_addr;
            OP_JZ: begin
              if (ac_q == '0) pc_d = operand_addr;
            end
            OP_SETOP: op_d = ir_q[3:0];
            OP_ALUI: begin
              if (div_by_zero) begin
                ac_d  = '1;
                err_d = 1'b1;
              end else begin
                ac_d = alu_result;
              end
            end
            default:  err_d = 1'b1;
          endcase
        end
      end
      ST_MEMRD: begin
        state_d = ST_FETCH;
        if (major == OP_LOAD) begin
          ac_d = mem_rdata;
        end else if (div_by_zero) begin
          ac_d  = '1;
          err_d = 1'b1;
        end else begin
          ac_d = alu_result;
        end
      end
      ST_HALTED: begin
        if (start) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Architectural state with asynchronous reset; reset abandons any in-flight instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
      ac_q    <= '0;
      op_q    <= ALU_ADD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // Memory and ALU drive, decoded straight from the current state so reset kills mem_we at once
  always_comb begin
    mem_addr  = pc_q;
    mem_we    = 1'b0;
    mem_wdata = ac_q;
    alu_op    = op_q;
    alu_a     = ac_q;
    alu_b     = DATA_W'(ir_q[11:0]);
    if (state_q == ST_EXEC) begin
      mem_addr = operand_addr;
      if (major == OP_STORE) mem_we = 1'b1;
    end
    if (state_q == ST_MEMRD) alu_b = mem_rdata;
  end

  assign pc     = pc_q;
  assign acc    = ac_q;
  assign halted = (state_q == ST_HALTED);
  assign err    = err_q;

endmodule
